// File: rtl/store_port_arbiter.sv
// Round-robin arbiter sharing the single dcache store port between NUM_PORTS requesters.
// One accepted store is held in an output register until the cache grants it.
module store_port_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 56,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          stall_i,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_be_i,
    input  logic [NUM_PORTS*2-1:0]        req_size_i,
    output logic [NUM_PORTS-1:0]          req_gnt_o,
    output logic                          mem_req_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_data_o,
    output logic [DATA_W/8-1:0]           mem_be_o,
    output logic [1:0]                    mem_size_o,
    output logic [IDX_W-1:0]              mem_owner_o,
    input  logic                          mem_gnt_i,
    output logic                          idle_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  prio_q, prio_d;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W:0]    cand;
    logic              found;
    logic              accept;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [1:0]        size_q, size_d;
    logic [IDX_W-1:0]  owner_q, owner_d;

    // Cyclic search for the first valid requester starting at prio_q.
    always_comb begin
        winner = prio_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, prio_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
                cand = cand - (IDX_W+1)'(NUM_PORTS);
            end
            if (!found && req_valid_i[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    assign accept = !stall_i && found && (state_q == StIdle || mem_gnt_i);

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        size_d  = size_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        if (accept) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (winner == IDX_W'(k)) begin
                    addr_d = req_addr_i[k*ADDR_W +: ADDR_W];
                    data_d = req_data_i[k*DATA_W +: DATA_W];
                    be_d   = req_be_i[k*BE_W +: BE_W];
                    size_d = req_size_i[k*2 +: 2];
                end
            end
            owner_d = winner;
            prio_d  = (winner == IDX_W'(NUM_PORTS-1)) ? '0 : winner + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            prio_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            size_q  <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            size_q  <= size_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StReq;
            StReq:  if (mem_gnt_i && !accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_gnt_o = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            req_gnt_o[k] = accept && (winner == IDX_W'(k));
        end
        mem_req_o   = (state_q == StReq);
        mem_addr_o  = addr_q;
        mem_data_o  = data_q;
        mem_be_o    = be_q;
        mem_size_o  = size_q;
        mem_owner_o = owner_q;
        idle_o      = (state_q == StIdle) && !(|req_valid_i);
    end

endmodule

// File: tb/tb_store_port_arbiter.sv
// Directed bench for store_port_arbiter: a 2-port instance for most scenarios and a
// 4-port instance for priority wrap-around.
`timescale 1ns/1ps
module tb_store_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic stall;
    always #5 clk = ~clk;

    logic [1:0]   v2;
    logic [111:0] a2;
    logic [127:0] d2;
    logic [15:0]  be2;
    logic [3:0]   s2;
    logic [1:0]   g2;
    logic         mreq2;
    logic [55:0]  maddr2;
    logic [63:0]  mdata2;
    logic [7:0]   mbe2;
    logic [1:0]   msize2;
    logic [0:0]   mown2;
    logic         mgnt2;
    logic         idle2;

    logic [3:0]   v4;
    logic [223:0] a4;
    logic [255:0] d4;
    logic [31:0]  be4;
    logic [7:0]   s4;
    logic [3:0]   g4;
    logic         mreq4;
    logic [55:0]  maddr4;
    logic [63:0]  mdata4;
    logic [7:0]   mbe4;
    logic [1:0]   msize4;
    logic [1:0]   mown4;
    logic         mgnt4;
    logic         idle4;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    store_port_arbiter #(.NUM_PORTS(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .req_valid_i(v2), .req_addr_i(a2), .req_data_i(d2), .req_be_i(be2),
        .req_size_i(s2), .req_gnt_o(g2), .mem_req_o(mreq2), .mem_addr_o(maddr2),
        .mem_data_o(mdata2), .mem_be_o(mbe2), .mem_size_o(msize2),
        .mem_owner_o(mown2), .mem_gnt_i(mgnt2), .idle_o(idle2)
    );

    store_port_arbiter #(.NUM_PORTS(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(1'b0),
        .req_valid_i(v4), .req_addr_i(a4), .req_data_i(d4), .req_be_i(be4),
        .req_size_i(s4), .req_gnt_o(g4), .mem_req_o(mreq4), .mem_addr_o(maddr4),
        .mem_data_o(mdata4), .mem_be_o(mbe4), .mem_size_o(msize4),
        .mem_owner_o(mown4), .mem_gnt_i(mgnt4), .idle_o(idle4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        v2 = '0; a2 = '0; d2 = '0; be2 = '0; s2 = '0; mgnt2 = 1'b0;
        v4 = '0; a4 = '0; d4 = '0; be4 = '0; s4 = '0; mgnt4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        v2 = '0; a2 = '0; d2 = '0; be2 = '0; s2 = '0; mgnt2 = 1'b0;
        v4 = '0; a4 = '0; d4 = '0; be4 = '0; s4 = '0; mgnt4 = 1'b0;
        tick();
        chk_cnt++;
        if (mreq2 !== 1'b0 || g2 !== 2'b00 || idle2 !== 1'b1) begin
            $display("FAIL reset_ctrl: req=%b gnt=%b idle=%b, want 0 00 1", mreq2, g2, idle2);
        end else pass_cnt++;
        chk_cnt++;
        if (maddr2 !== 56'h0 || mdata2 !== 64'h0 || mbe2 !== 8'h0 || msize2 !== 2'h0
            || mown2 !== 1'b0) begin
            $display("FAIL reset_payload: addr=%h data=%h be=%h size=%h own=%h, want all 0",
                     maddr2, mdata2, mbe2, msize2, mown2);
        end else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        v2[0] = 1'b1; a2[55:0] = 56'h80; d2[63:0] = 64'hDEAD; be2[7:0] = 8'hFF;
        s2[1:0] = 2'd3; mgnt2 = 1'b1;
        #1;
        chk_cnt++;
        if (g2 !== 2'b01) $display("FAIL single_gnt: got %b want 01", g2);
        else pass_cnt++;
        tick();
        v2 = '0;
        chk_cnt++;
        if (mreq2 !== 1'b1 || mown2 !== 1'b0 || maddr2 !== 56'h80 || mdata2 !== 64'hDEAD
            || mbe2 !== 8'hFF || msize2 !== 2'd3) begin
            $display("FAIL single_issue: req=%b own=%h addr=%h data=%h be=%h size=%h",
                     mreq2, mown2, maddr2, mdata2, mbe2, msize2);
        end else pass_cnt++;
        #1;
        chk_cnt++;
        if (g2 !== 2'b00) $display("FAIL single_nogrant: got %b want 00", g2);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (mreq2 !== 1'b0 || idle2 !== 1'b1) begin
            $display("FAIL single_idle: req=%b idle=%b want 0 1", mreq2, idle2);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        do_reset();
        v2 = 2'b11; a2[55:0] = 56'h100; a2[111:56] = 56'h200; mgnt2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk_cnt++;
            if (g2 !== exp_g) $display("FAIL b2b_gnt[%0d]: got %b want %b", i, g2, exp_g);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if (mreq2 !== 1'b1 || mown2 !== 1'(i % 2)
                || maddr2 !== ((i % 2 == 0) ? 56'h100 : 56'h200)) begin
                $display("FAIL b2b_owner[%0d]: req=%b own=%h addr=%h", i, mreq2, mown2, maddr2);
            end else pass_cnt++;
        end
        v2 = '0;
        tick();
        chk_cnt++;
        if (mreq2 !== 1'b0) $display("FAIL b2b_drain: req=%b want 0", mreq2);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        // Prio is 0 after the last contention winner was port1.
        v2 = 2'b01; a2[55:0] = 56'h300; d2[63:0] = 64'h1111; be2[7:0] = 8'h0F; mgnt2 = 1'b0;
        #1;
        chk_cnt++;
        if (g2 !== 2'b01) $display("FAIL bp_first: got %b want 01", g2);
        else pass_cnt++;
        tick();
        v2 = 2'b11; a2[55:0] = 56'h999; a2[111:56] = 56'h444;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++;
            if (g2 !== 2'b00 || mreq2 !== 1'b1 || maddr2 !== 56'h300 || mdata2 !== 64'h1111
                || mbe2 !== 8'h0F || mown2 !== 1'b0) begin
                $display("FAIL bp_hold[%0d]: gnt=%b req=%b addr=%h data=%h be=%h own=%h",
                         i, g2, mreq2, maddr2, mdata2, mbe2, mown2);
            end else pass_cnt++;
            tick();
        end
        mgnt2 = 1'b1;
        #1;
        chk_cnt++;
        if (g2 !== 2'b10) $display("FAIL bp_release_gnt: got %b want 10", g2);
        else pass_cnt++;
        tick();
        v2 = '0;
        chk_cnt++;
        if (mreq2 !== 1'b1 || mown2 !== 1'b1 || maddr2 !== 56'h444) begin
            $display("FAIL bp_next: req=%b own=%h addr=%h", mreq2, mown2, maddr2);
        end else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        v2 = 2'b01; a2[55:0] = 56'h400; a2[111:56] = 56'h500; mgnt2 = 1'b0;
        tick();
        v2 = 2'b10; stall = 1'b1;
        #1;
        chk_cnt++;
        if (g2 !== 2'b00) $display("FAIL stall_nogrant: got %b want 00", g2);
        else pass_cnt++;
        tick();
        mgnt2 = 1'b1;
        #1;
        chk_cnt++;
        if (g2 !== 2'b00 || mreq2 !== 1'b1 || mown2 !== 1'b0) begin
            $display("FAIL stall_held: gnt=%b req=%b own=%h", g2, mreq2, mown2);
        end else pass_cnt++;
        tick();
        chk_cnt++;
        if (mreq2 !== 1'b0 || idle2 !== 1'b0) begin
            $display("FAIL stall_done: req=%b idle=%b want 0 0", mreq2, idle2);
        end else pass_cnt++;
        stall = 1'b0; mgnt2 = 1'b0;
        #1;
        chk_cnt++;
        if (g2 !== 2'b10) $display("FAIL stall_resume: got %b want 10", g2);
        else pass_cnt++;
        tick();
        v2 = '0;
        chk_cnt++;
        if (mreq2 !== 1'b1 || mown2 !== 1'b1 || maddr2 !== 56'h500) begin
            $display("FAIL stall_issue: req=%b own=%h addr=%h", mreq2, mown2, maddr2);
        end else pass_cnt++;
        mgnt2 = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        a4[2*56 +: 56] = 56'hA2; a4[3*56 +: 56] = 56'hA3; a4[0 +: 56] = 56'hA0;
        v4 = 4'b0100; mgnt4 = 1'b1;
        #1;
        chk_cnt++;
        if (g4 !== 4'b0100) $display("FAIL wrap_setup: got %b want 0100", g4);
        else pass_cnt++;
        tick();
        v4 = 4'b1001;
        #1;
        chk_cnt++;
        if (g4 !== 4'b1000) $display("FAIL wrap_p3: got %b want 1000", g4);
        else pass_cnt++;
        tick();
        v4 = 4'b0001;
        chk_cnt++;
        if (mown4 !== 2'd3 || maddr4 !== 56'hA3) begin
            $display("FAIL wrap_own3: own=%h addr=%h want 3 a3", mown4, maddr4);
        end else pass_cnt++;
        #1;
        chk_cnt++;
        if (g4 !== 4'b0001) $display("FAIL wrap_p0: got %b want 0001", g4);
        else pass_cnt++;
        tick();
        v4 = '0;
        chk_cnt++;
        if (mown4 !== 2'd0 || maddr4 !== 56'hA0 || mreq4 !== 1'b1) begin
            $display("FAIL wrap_own0: own=%h addr=%h req=%b", mown4, maddr4, mreq4);
        end else pass_cnt++;
        tick();
        chk_cnt++;
        if (mreq4 !== 1'b0 || idle4 !== 1'b1) begin
            $display("FAIL wrap_idle: req=%b idle=%b want 0 1", mreq4, idle4);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        v2 = 2'b01; a2[55:0] = 56'h600; mgnt2 = 1'b0;
        tick();
        v2 = '0;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (mreq2 !== 1'b0 || maddr2 !== 56'h0) begin
            $display("FAIL rstmid_async: req=%b addr=%h want 0 0", mreq2, maddr2);
        end else pass_cnt++;
        #2;
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if (mreq2 !== 1'b0 || idle2 !== 1'b1 || g2 !== 2'b00) begin
            $display("FAIL rstmid_quiet: req=%b idle=%b gnt=%b", mreq2, idle2, g2);
        end else pass_cnt++;
        v2 = 2'b11;
        #1;
        chk_cnt++;
        if (g2 !== 2'b01) $display("FAIL rstmid_prio: got %b want 01", g2);
        else pass_cnt++;
        tick();
        v2 = '0; mgnt2 = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stall();
        test_wrap();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
